// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and forwarding unit:
// state encoding, the zero register index and the pipeline control bundle.
package pipe_ctrl_pkg;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = RUN,
        ST_MEM_WAIT = MEM_WAIT,
        ST_ERROR    = ERROR
    } state_e;

    // Enables / flush controls driven into the pipeline registers and PC
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_write;
        logic memwb_bubble;
    } pipe_ctl_t;

    // Whole pipe held while memory is outstanding; a nop drains into WB
    function automatic pipe_ctl_t ctl_freeze();
        pipe_ctl_t c;
        c.pc_write     = 1'b0;
        c.ifid_write   = 1'b0;
        c.ifid_flush   = 1'b0;
        c.idex_flush   = 1'b0;
        c.exmem_write  = 1'b0;
        c.memwb_bubble = 1'b1;
        return c;
    endfunction

    // Normal-flow controls: taken branch beats load-use
    function automatic pipe_ctl_t ctl_run(input logic branch_taken, input logic load_use);
        pipe_ctl_t c;
        c.pc_write     = 1'b1;
        c.ifid_write   = 1'b1;
        c.ifid_flush   = 1'b0;
        c.idex_flush   = 1'b0;
        c.exmem_write  = 1'b1;
        c.memwb_bubble = 1'b0;
        if (branch_taken) begin
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (load_use) begin
            c.pc_write   = 1'b0;
            c.ifid_write = 1'b0;
            c.idex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc=1, holds at all-ones.
// Ports: clk, rst_n (async active-low), inc (count enable), count (value).
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Decodes load-use hazards,
// flushes on taken branches, freezes the pipe while data memory is busy and
// raises a sticky error when memory stalls for WAIT_MAX consecutive cycles.
// Inputs : Clk, Rst_n, ID operand fields (IFID_Rs/Rt/UsesRt), load in EX
//          (IDEX_MemRead/Rt), EX_BranchTaken, EXMEM_MemAccess, DMem_Ready.
// Outputs: PC/pipeline-register enables and flushes (combinational, zero
//          latency), Err, StallCount, FlushCount (saturating).
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Rt,
    input  logic             EX_BranchTaken,
    input  logic             EXMEM_MemAccess,
    input  logic             DMem_Ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Write,
    output logic             MEMWB_Bubble,
    output logic             Err,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] WAIT_ONE = CNT_W'(1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt, wait_inc;
    pipe_ctl_t        ctl;
    logic             mem_busy, load_use;

    // Hazard decode
    assign mem_busy = EXMEM_MemAccess & ~DMem_Ready;
    assign load_use = IDEX_MemRead && (IDEX_Rt != REG_ZERO) &&
                      ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    assign wait_inc = wait_cnt + WAIT_ONE;

    // State and wait-counter register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next state and pipeline controls
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        ctl       = ctl_run(1'b0, 1'b0);
        case (state)
            ST_RUN: begin
                if (mem_busy) begin
                    ctl       = ctl_freeze();
                    wait_nxt  = WAIT_ONE;
                    // The first busy cycle already counts as a wait cycle
                    state_nxt = (WAIT_ONE >= WAIT_LIM) ? ST_ERROR : ST_MEM_WAIT;
                end else begin
                    ctl = ctl_run(EX_BranchTaken, load_use);
                end
            end
            ST_MEM_WAIT: begin
                if (!DMem_Ready) begin
                    // EX is held, so a taken branch here is acted on at release
                    ctl      = ctl_freeze();
                    wait_nxt = wait_inc;
                    if (wait_inc >= WAIT_LIM) begin
                        state_nxt = ST_ERROR;
                    end
                end else begin
                    ctl       = ctl_run(EX_BranchTaken, load_use);
                    wait_nxt  = '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_ERROR: begin
                ctl = ctl_freeze();
            end
            default: begin
                ctl       = ctl_freeze();
                state_nxt = ST_ERROR;
            end
        endcase
    end

    assign PC_Write     = ctl.pc_write;
    assign IFID_Write   = ctl.ifid_write;
    assign IFID_Flush   = ctl.ifid_flush;
    assign IDEX_Flush   = ctl.idex_flush;
    assign EXMEM_Write  = ctl.exmem_write;
    assign MEMWB_Bubble = ctl.memwb_bubble;
    assign Err          = (state == ST_ERROR);

    // Performance counters: stalled cycles and acted-on branch flushes
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .inc   (~ctl.pc_write),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .inc   (ctl.ifid_flush),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned CNT_W    = 5;
    localparam int          MAXC     = (1 << CNT_W) - 1;

    logic             Clk;
    logic             Rst_n;
    logic [4:0]       IFID_Rs, IFID_Rt, IDEX_Rt;
    logic             IFID_UsesRt, IDEX_MemRead, EX_BranchTaken, EXMEM_MemAccess, DMem_Ready;
    logic             PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Bubble, Err;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: sticky error flag, length of the current memory wait, counters
    bit m_err    = 1'b0;
    int m_waited = 0;
    int m_stall  = 0;
    int m_flush  = 0;
    logic [5:0] exp_ctl;
    logic       exp_frozen;

    pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .IFID_Rs         (IFID_Rs),
        .IFID_Rt         (IFID_Rt),
        .IFID_UsesRt     (IFID_UsesRt),
        .IDEX_MemRead    (IDEX_MemRead),
        .IDEX_Rt         (IDEX_Rt),
        .EX_BranchTaken  (EX_BranchTaken),
        .EXMEM_MemAccess (EXMEM_MemAccess),
        .DMem_Ready      (DMem_Ready),
        .PC_Write        (PC_Write),
        .IFID_Write      (IFID_Write),
        .IFID_Flush      (IFID_Flush),
        .IDEX_Flush      (IDEX_Flush),
        .EXMEM_Write     (EXMEM_Write),
        .MEMWB_Bubble    (MEMWB_Bubble),
        .Err             (Err),
        .StallCount      (StallCount),
        .FlushCount      (FlushCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Pipe is frozen when in error, when an outstanding wait has no ready,
    // or when a new memory access starts without ready.
    function automatic logic frozen_f(input bit err, input int waited,
                                      input logic acc, input logic rdy);
        if (err) return 1'b1;
        if (waited > 0) return !rdy;
        return acc && !rdy;
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_bubble}
    function automatic logic [5:0] ctl_f(input logic frz, input logic br, input logic mr,
                                         input logic [4:0] drt, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic uses_rt);
        logic lu;
        lu = mr && (drt != 5'd0) && ((drt == rs) || (uses_rt && (drt == rt)));
        if (frz)     return 6'b000001;
        else if (br) return 6'b111110;
        else if (lu) return 6'b000110;
        else         return 6'b110010;
    endfunction

    always_comb begin
        exp_frozen = frozen_f(m_err, m_waited, EXMEM_MemAccess, DMem_Ready);
        exp_ctl    = ctl_f(exp_frozen, EX_BranchTaken, IDEX_MemRead, IDEX_Rt,
                           IFID_Rs, IFID_Rt, IFID_UsesRt);
    end

    // Model state update
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_err    <= 1'b0;
            m_waited <= 0;
            m_stall  <= 0;
            m_flush  <= 0;
        end else begin
            if (!exp_ctl[5] && (m_stall < MAXC)) m_stall <= m_stall + 1;
            if (exp_ctl[3] && (m_flush < MAXC))  m_flush <= m_flush + 1;
            if (!m_err) begin
                if (exp_frozen) begin
                    m_waited <= m_waited + 1;
                    if (m_waited + 1 >= int'(WAIT_MAX)) m_err <= 1'b1;
                end else begin
                    m_waited <= 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge Clk) begin
        if (chk_en) begin
            check("m_pc_write",     PC_Write,     exp_ctl[5]);
            check("m_ifid_write",   IFID_Write,   exp_ctl[4]);
            check("m_ifid_flush",   IFID_Flush,   exp_ctl[3]);
            check("m_idex_flush",   IDEX_Flush,   exp_ctl[2]);
            check("m_exmem_write",  EXMEM_Write,  exp_ctl[1]);
            check("m_memwb_bubble", MEMWB_Bubble, exp_ctl[0]);
            check("m_err",          Err,          m_err);
            check("m_stall_count",  StallCount,   m_stall);
            check("m_flush_count",  FlushCount,   m_flush);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        IFID_Rs = 5'd1; IFID_Rt = 5'd2; IFID_UsesRt = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0; EX_BranchTaken = 1'b0;
        EXMEM_MemAccess = 1'b0; DMem_Ready = 1'b1;
    endtask

    initial begin
        Rst_n = 1'b0;
        idle();
        chk_en = 1'b1;
        tick(); tick();
        check("rst_pc_write", PC_Write, 1);
        check("rst_idex_flush", IDEX_Flush, 0);
        check("rst_bubble", MEMWB_Bubble, 0);
        check("rst_stall", StallCount, 0);
        check("rst_flush", FlushCount, 0);
        check("rst_err", Err, 0);
        Rst_n = 1'b1;

        // Load-use stall for one cycle
        tick(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8; #1;
        check("lu_pc_write", PC_Write, 0);
        check("lu_ifid_write", IFID_Write, 0);
        check("lu_idex_flush", IDEX_Flush, 1);
        check("lu_exmem_write", EXMEM_Write, 1);
        tick(); idle(); #1;
        check("lu_stall_count", StallCount, 1);
        check("lu_released", PC_Write, 1);

        // No false hazards
        tick(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; #1;
        check("nh_zero_reg", PC_Write, 1);
        tick(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd9; IFID_Rt = 5'd9; IFID_Rs = 5'd3;
        IFID_UsesRt = 1'b0; #1;
        check("nh_rt_unused", PC_Write, 1);
        tick(); idle(); #1;
        check("nh_stall_count", StallCount, 1);

        // Taken branch, then branch together with load-use
        tick(); EX_BranchTaken = 1'b1; #1;
        check("br_ifid_flush", IFID_Flush, 1);
        check("br_idex_flush", IDEX_Flush, 1);
        tick(); idle(); #1;
        check("br_flush_count", FlushCount, 1);
        tick(); EX_BranchTaken = 1'b1; IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8; #1;
        check("brlu_pc_write", PC_Write, 1);
        check("brlu_ifid_flush", IFID_Flush, 1);
        tick(); idle(); #1;
        check("brlu_flush_count", FlushCount, 2);
        check("brlu_stall_count", StallCount, 1);

        // Memory wait of 3 cycles with a branch held in EX, release on the 4th
        for (int k = 0; k < 3; k++) begin
            tick(); EXMEM_MemAccess = 1'b1; DMem_Ready = 1'b0; EX_BranchTaken = 1'b1; #1;
            check("mw_pc_write", PC_Write, 0);
            check("mw_exmem_write", EXMEM_Write, 0);
            check("mw_bubble", MEMWB_Bubble, 1);
            check("mw_ifid_flush", IFID_Flush, 0);
        end
        tick(); DMem_Ready = 1'b1; #1;
        check("mw_rel_pc_write", PC_Write, 1);
        check("mw_rel_bubble", MEMWB_Bubble, 0);
        check("mw_rel_ifid_flush", IFID_Flush, 1);
        tick(); idle(); #1;
        check("mw_stall_count", StallCount, 4);
        check("mw_flush_count", FlushCount, 3);
        check("mw_back_run", PC_Write, 1);

        // Timeout after WAIT_MAX wait cycles, sticky until reset
        for (int k = 0; k < 4; k++) begin
            tick(); EXMEM_MemAccess = 1'b1; DMem_Ready = 1'b0; #1;
            check("to_err_pending", Err, 0);
        end
        tick(); idle(); #1;
        check("to_err_set", Err, 1);
        check("to_frozen", PC_Write, 0);
        check("to_bubble", MEMWB_Bubble, 1);
        repeat (40) tick();
        check("to_stall_saturated", StallCount, MAXC);
        check("to_err_sticky", Err, 1);
        tick(); Rst_n = 1'b0; #1;
        check("to_err_cleared", Err, 0);
        check("to_stall_cleared", StallCount, 0);
        tick(); Rst_n = 1'b1;

        // Asynchronous reset in the middle of a memory wait
        tick(); EXMEM_MemAccess = 1'b1; DMem_Ready = 1'b0;
        tick();
        tick(); EXMEM_MemAccess = 1'b0; #1;
        check("ar_still_waiting", PC_Write, 0);
        #1 Rst_n = 1'b0;
        #1;
        check("ar_pc_write", PC_Write, 1);
        check("ar_bubble", MEMWB_Bubble, 0);
        check("ar_stall_count", StallCount, 0);
        tick(); Rst_n = 1'b1; #1;
        check("ar_run_after", PC_Write, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!Rst_n) Rst_n = 1'b1;
            else if ($urandom_range(0, 99) < 3) Rst_n = 1'b0;
            IFID_Rs         = 5'($urandom_range(0, 3));
            IFID_Rt         = 5'($urandom_range(0, 3));
            IDEX_Rt         = 5'($urandom_range(0, 3));
            IFID_UsesRt     = 1'($urandom_range(0, 1));
            IDEX_MemRead    = ($urandom_range(0, 99) < 50);
            EX_BranchTaken  = ($urandom_range(0, 99) < 20);
            EXMEM_MemAccess = ($urandom_range(0, 99) < 35);
            DMem_Ready      = ($urandom_range(0, 99) < 55);
        end

        @(negedge Clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
